lcd_backlight_seq: RTL and testbench

//  Backlight power sequencer/fader upstream of the LCD backlight PWM stage.

---
 rtl/lcd_backlight_seq_pkg.sv | 19 +
 rtl/lcd_bl_tick_gen.sv | 40 ++++
 rtl/lcd_backlight_seq.sv | 139 +++++++++++++
 tb/tb_lcd_backlight_seq.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_backlight_seq_pkg.sv
// Shared types and helpers for the backlight sequencer.
// State encoding and a saturating clamp used by the target and step logic.
package lcd_backlight_seq_pkg;

   typedef enum logic [1:0] {
      ST_OFF   = 2'd0,
      ST_DELAY = 2'd1,
      ST_RAMP  = 2'd2,
      ST_ON    = 2'd3
   } bl_state_t;

   function automatic int unsigned clamp_max(
      input int unsigned v,
      input int unsigned lim
   );
      return (v > lim) ? lim : v;
   endfunction

endpackage

// File: rtl/lcd_bl_tick_gen.sv
// PWM period counter and ramp-step divider.
// step_tick leads the step-tick period by one cycle so duty lands on it.
module lcd_bl_tick_gen #(
   parameter int PWM_PERIOD   = 4000,
   parameter int STEP_PERIODS = 4
) (
   input  logic I_clk,
   input  logic I_rst,
   output logic O_period_start,
   output logic step_tick
);

   localparam int CW = $clog2(PWM_PERIOD);
   localparam int SW = $clog2(STEP_PERIODS + 1);
   localparam logic [CW-1:0] P_LAST = CW'(PWM_PERIOD - 1);
   localparam logic [SW-1:0] S_LAST = SW'(STEP_PERIODS - 1);

   logic [CW-1:0] cnt_q;
   logic [SW-1:0] scnt_q;
   logic          ps_q;
   logic          wrap;

   assign wrap           = (cnt_q == P_LAST);
   assign step_tick      = wrap && (scnt_q == S_LAST);
   assign O_period_start = ps_q;

   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         cnt_q  <= '0;
         scnt_q <= '0;
         ps_q   <= 1'b0;
      end else begin
         cnt_q <= wrap ? '0 : cnt_q + 1'b1;
         ps_q  <= wrap;
         if (wrap)
            scnt_q <= (scnt_q == S_LAST) ? '0 : scnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/lcd_backlight_seq.sv
// Backlight power sequencer: init wait, power-on delay, duty ramp/fade.
// Loss of panel init cuts the backlight off immediately, without fading.
module lcd_backlight_seq
   import lcd_backlight_seq_pkg::*;
#(
   parameter int PWM_PERIOD   = 4000,
   parameter int DUTY_W       = 12,
   parameter int DEF_DUTY     = 1000,
   parameter int STEP_SIZE    = 40,
   parameter int STEP_PERIODS = 4,
   parameter int ON_DELAY_CYC = 10000000
) (
   input  logic              I_clk,
   input  logic              I_rst,
   input  logic              I_init_done,
   input  logic              I_bl_en,
   input  logic              I_req_valid,
   input  logic [DUTY_W-1:0] I_req_duty,
   output logic              O_req_ready,
   output logic              O_pwmbl_on_sw,
   output logic [DUTY_W-1:0] O_duty,
   output logic              O_period_start
);

   localparam int DLW = $clog2(ON_DELAY_CYC + 1);
   localparam logic [DLW-1:0] DLY_LAST = DLW'(ON_DELAY_CYC - 1);

   bl_state_t         state_q, state_d;
   logic [DUTY_W-1:0] duty_q, duty_d;
   logic [DUTY_W-1:0] target_q, target_d;
   logic [DLW-1:0]    dly_q, dly_d;
   logic              on_q, on_d;

   logic              step_tick;
   logic              go;
   logic              accept;
   logic [DUTY_W-1:0] req_clamped;
   logic [DUTY_W-1:0] ramp_tgt;
   logic              up;
   logic [DUTY_W:0]   mag;
   logic [DUTY_W-1:0] step;
   logic [DUTY_W-1:0] stepped;

   lcd_bl_tick_gen #(
      .PWM_PERIOD   (PWM_PERIOD),
      .STEP_PERIODS (STEP_PERIODS)
   ) u_tick (
      .I_clk          (I_clk),
      .I_rst          (I_rst),
      .O_period_start (O_period_start),
      .step_tick      (step_tick)
   );

   assign go          = I_bl_en & I_init_done;
   assign O_req_ready = (state_q != ST_RAMP);
   assign accept      = I_req_valid & O_req_ready;
   assign req_clamped =
      DUTY_W'(clamp_max(32'(I_req_duty), PWM_PERIOD));

   // Extra bit keeps the distance unsigned and wrap-free in both directions
   assign ramp_tgt = go ? target_q : '0;
   assign up       = (ramp_tgt > duty_q);
   assign mag      = up ? ({1'b0, ramp_tgt} - {1'b0, duty_q})
                        : ({1'b0, duty_q} - {1'b0, ramp_tgt});
   assign step     = DUTY_W'(clamp_max(32'(mag), STEP_SIZE));
   assign stepped  = up ? duty_q + step : duty_q - step;

   always_comb begin
      state_d  = state_q;
      duty_d   = duty_q;
      on_d     = on_q;
      dly_d    = dly_q;
      target_d = target_q;
      if (accept)
         target_d = req_clamped;
      unique case (state_q)
         ST_OFF: begin
            duty_d = '0;
            on_d   = 1'b0;
            dly_d  = '0;
            if (go)
               state_d = ST_DELAY;
         end
         ST_DELAY: begin
            if (!go) begin
               state_d = ST_OFF;
            end else if (dly_q == DLY_LAST) begin
               state_d = ST_RAMP;
               on_d    = 1'b1;
            end else begin
               dly_d = dly_q + 1'b1;
            end
         end
         ST_RAMP: begin
            if (step_tick)
               duty_d = stepped;
            if (duty_d == ramp_tgt) begin
               if (ramp_tgt != '0) begin
                  state_d = ST_ON;
               end else begin
                  state_d = ST_OFF;
                  on_d    = 1'b0;
               end
            end
         end
         ST_ON: begin
            if (!I_bl_en)
               state_d = ST_RAMP;
            else if (accept && (req_clamped != duty_q))
               state_d = ST_RAMP;
         end
      endcase
      if ((state_q != ST_OFF) && !I_init_done) begin
         state_d = ST_OFF;
         duty_d  = '0;
         on_d    = 1'b0;
      end
   end

   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         state_q  <= ST_OFF;
         duty_q   <= '0;
         on_q     <= 1'b0;
         dly_q    <= '0;
         target_q <= DUTY_W'(DEF_DUTY);
      end else begin
         state_q  <= state_d;
         duty_q   <= duty_d;
         on_q     <= on_d;
         dly_q    <= dly_d;
         target_q <= target_d;
      end
   end

   assign O_duty        = duty_q;
   assign O_pwmbl_on_sw = on_q;

endmodule

// File: tb/tb_lcd_backlight_seq.sv
// Bench for lcd_backlight_seq: cycle-time reference model feeding a
// scoreboard queue, popped and compared by a negedge monitor.
module tb_lcd_backlight_seq;

   localparam int P    = 10;
   localparam int S    = 2;
   localparam int STEP = 3;
   localparam int D    = 20;
   localparam int DEF  = 7;
   localparam int W    = 4;

   localparam int M_OFF   = 0;
   localparam int M_DELAY = 1;
   localparam int M_RAMP  = 2;
   localparam int M_ON    = 3;

   logic         I_clk = 1'b0;
   logic         I_rst = 1'b1;
   logic         I_init_done = 1'b0;
   logic         I_bl_en = 1'b0;
   logic         I_req_valid = 1'b0;
   logic [W-1:0] I_req_duty = '0;
   logic         O_req_ready;
   logic         O_pwmbl_on_sw;
   logic [W-1:0] O_duty;
   logic         O_period_start;

   always #5 I_clk = ~I_clk;

   lcd_backlight_seq #(
      .PWM_PERIOD   (P),
      .DUTY_W       (W),
      .DEF_DUTY     (DEF),
      .STEP_SIZE    (STEP),
      .STEP_PERIODS (S),
      .ON_DELAY_CYC (D)
   ) dut (
      .I_clk          (I_clk),
      .I_rst          (I_rst),
      .I_init_done    (I_init_done),
      .I_bl_en        (I_bl_en),
      .I_req_valid    (I_req_valid),
      .I_req_duty     (I_req_duty),
      .O_req_ready    (O_req_ready),
      .O_pwmbl_on_sw  (O_pwmbl_on_sw),
      .O_duty         (O_duty),
      .O_period_start (O_period_start)
   );

   typedef struct {
      bit on;
      int duty;
      bit ps;
      bit rdy;
      bit forced;
   } exp_t;

   exp_t sbq[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference model: time is the cycle index t since the last reset edge;
   // period starts sit at t = k*P (k>=1), step ticks at t = k*P*S.
   int t = 0;
   int mode = M_OFF;
   int m_duty = 0;
   int m_on = 0;
   int m_tgt = DEF;
   int m_dly = 0;
   bit armed = 1'b0;

   always @(posedge I_clk) begin
      exp_t e;
      bit   acc, go;
      int   nt, rt, gap;
      e.forced = 1'b0;
      if (I_rst) begin
         armed  = 1'b1;
         t      = 0;
         mode   = M_OFF;
         m_duty = 0;
         m_on   = 0;
         m_tgt  = DEF;
         m_dly  = 0;
         e.forced = 1'b1;
      end else if (armed) begin
         acc = I_req_valid && (mode != M_RAMP);
         nt  = (int'(I_req_duty) > P) ? P : int'(I_req_duty);
         go  = I_bl_en && I_init_done;
         if (mode != M_OFF && !I_init_done) begin
            e.forced = 1'b1;
            mode   = M_OFF;
            m_duty = 0;
            m_on   = 0;
         end else begin
            case (mode)
               M_OFF: if (go) begin
                  mode  = M_DELAY;
                  m_dly = 0;
               end
               M_DELAY: begin
                  if (!go) mode = M_OFF;
                  else begin
                     m_dly++;
                     if (m_dly == D) begin
                        mode = M_RAMP;
                        m_on = 1;
                     end
                  end
               end
               M_RAMP: begin
                  rt = go ? m_tgt : 0;
                  if ((t + 1) % (P * S) == 0) begin
                     gap = rt - m_duty;
                     if (gap > STEP) gap = STEP;
                     if (gap < -STEP) gap = -STEP;
                     m_duty += gap;
                  end
                  if (m_duty == rt) begin
                     if (rt != 0) mode = M_ON;
                     else begin
                        mode = M_OFF;
                        m_on = 0;
                     end
                  end
               end
               default: begin
                  if (!I_bl_en || (acc && nt != m_duty))
                     mode = M_RAMP;
               end
            endcase
         end
         if (acc) m_tgt = nt;
         t++;
      end
      if (armed) begin
         e.on   = (m_on != 0);
         e.duty = m_duty;
         e.ps   = (t > 0) && (t % P == 0);
         e.rdy  = (mode != M_RAMP);
         sbq.push_back(e);
      end
   end

   logic [W-1:0] prev_duty;
   bit           have_prev = 1'b0;

   always @(negedge I_clk) begin
      exp_t e;
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         n_cmp++;
         if (O_pwmbl_on_sw !== e.on || O_duty !== W'(e.duty) ||
             O_period_start !== e.ps || O_req_ready !== e.rdy) begin
            n_bad++;
            $display("FAIL outputs @%0t: got on=%b duty=%0d ps=%b rdy=%b, want on=%b duty=%0d ps=%b rdy=%b",
                     $time, O_pwmbl_on_sw, O_duty, O_period_start, O_req_ready,
                     e.on, e.duty, e.ps, e.rdy);
         end
         if (have_prev && O_duty != prev_duty) begin
            n_cmp++;
            if (!O_period_start && !e.forced) begin
               n_bad++;
               $display("FAIL duty_timing @%0t: duty %0d->%0d with period_start=%b, want 1",
                        $time, prev_duty, O_duty, O_period_start);
            end
         end
         prev_duty = O_duty;
         have_prev = 1'b1;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge I_clk);
         #1;
      end
   endtask

   task automatic check(input string name, input int got, input int want);
      n_cmp++;
      if (got != want) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", name, got, want);
      end
   endtask

   // Edges until on_sw rises: one edge into DELAY plus D DELAY cycles
   task automatic wait_on_rise(input string name);
      int n;
      n = 0;
      while (O_pwmbl_on_sw !== 1'b1 && n < 200) begin
         tick(1);
         n++;
      end
      check(name, n, D + 1);
   endtask

   task automatic wait_duty(input string name, input int v);
      int n;
      n = 0;
      while (O_duty !== W'(v) && n < 200) begin
         tick(1);
         n++;
      end
      n_cmp++;
      if (n >= 200) begin
         n_bad++;
         $display("FAIL %s: duty=%0d after 200 cycles, want %0d", name, O_duty, v);
      end
   endtask

   task automatic request(input int v);
      I_req_valid = 1'b1;
      I_req_duty  = W'(v);
      tick(1);
      I_req_valid = 1'b0;
   endtask

   initial begin
      tick(3);
      check("reset_on", int'(O_pwmbl_on_sw), 0);
      check("reset_duty", int'(O_duty), 0);
      check("reset_ps", int'(O_period_start), 0);
      check("reset_ready", int'(O_req_ready), 1);
      I_rst = 1'b0;

      I_init_done = 1'b1;
      I_bl_en     = 1'b1;
      wait_on_rise("t1_on_delay");
      tick(100);
      check("t1_duty", int'(O_duty), DEF);
      check("t1_ready", int'(O_req_ready), 1);

      request(2);
      check("t2_ready_low", int'(O_req_ready), 0);
      tick(60);
      check("t2_duty", int'(O_duty), 2);
      request(15);
      tick(80);
      check("t2_clamp", int'(O_duty), P);
      request(5);
      tick(60);
      check("t2_duty5", int'(O_duty), 5);

      I_bl_en = 1'b0;
      tick(80);
      check("t3_duty", int'(O_duty), 0);
      check("t3_on", int'(O_pwmbl_on_sw), 0);

      I_bl_en = 1'b1;
      wait_on_rise("t4_on_delay");
      wait_duty("t4_reach3", 3);
      I_init_done = 1'b0;
      tick(1);
      check("t4_cut_duty", int'(O_duty), 0);
      check("t4_cut_on", int'(O_pwmbl_on_sw), 0);
      I_bl_en = 1'b0;
      tick(3);
      I_init_done = 1'b1;
      tick(3);

      I_bl_en = 1'b1;
      tick(16);
      I_bl_en = 1'b0;
      tick(1);
      check("t5_off", int'(O_pwmbl_on_sw), 0);
      I_bl_en = 1'b1;
      wait_on_rise("t5_restart");
      tick(100);

      I_bl_en = 1'b0;
      tick(80);
      I_bl_en = 1'b1;
      wait_on_rise("t6_on_delay");
      tick(25);
      I_rst = 1'b1;
      tick(1);
      I_rst = 1'b0;
      check("t6_rst_on", int'(O_pwmbl_on_sw), 0);
      check("t6_rst_duty", int'(O_duty), 0);
      check("t6_rst_ready", int'(O_req_ready), 1);
      wait_on_rise("t6_on_delay2");
      tick(100);
      check("t6_def_duty", int'(O_duty), DEF);

      for (int i = 0; i < 3000; i++) begin
         I_rst = ($urandom_range(999) == 0);
         if ($urandom_range(49) == 0) I_bl_en = ~I_bl_en;
         if (I_init_done) begin
            if ($urandom_range(299) == 0) I_init_done = 1'b0;
         end else if ($urandom_range(19) == 0) begin
            I_init_done = 1'b1;
         end
         I_req_valid = ($urandom_range(14) == 0);
         I_req_duty  = W'($urandom_range(15));
         tick(1);
      end
      I_rst       = 1'b0;
      I_req_valid = 1'b0;
      tick(2);
      @(negedge I_clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
